// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the TLB walk controller.
// Holds the walker state encoding, PTE field positions and the PTE address helper.
package mmu_pkg;

  localparam int MMU_VA_W      = 32;
  localparam int MMU_PAGE_BITS = 12;
  localparam int VPN_W         = MMU_VA_W - MMU_PAGE_BITS;
  localparam int PPN_W         = MMU_VA_W - MMU_PAGE_BITS;

  // PTE layout: [31:12] PPN, [1] dirty, [0] valid
  localparam int PTE_V       = 0;
  localparam int PTE_D       = 1;
  localparam int PTE_PPN_LSB = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_CHECK     = 3'd2,
    ST_WALK_REQ  = 3'd3,
    ST_WALK_WAIT = 3'd4,
    ST_FILL      = 3'd5
  } walk_state_e;

  // Address of the PTE for a VPN: base + VPN*4, wrapping modulo 2^32.
  function automatic logic [MMU_VA_W-1:0] pte_addr(input logic [MMU_VA_W-1:0] i_ptbr,
                                                    input logic [VPN_W-1:0]    i_vpn);
    return i_ptbr + {{(MMU_VA_W-VPN_W-2){1'b0}}, i_vpn, 2'b00};
  endfunction

endpackage

// File: rtl/tlb_walk_timeout.sv
// tlb_walk_timeout: loadable down-counter bounding the wait for a PTE.
// Loading starts a window of WALK_TIMEOUT counted cycles; o_expired flags
// the last cycle of that window.
module tlb_walk_timeout #(
  parameter int WALK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(WALK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WALK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Counter: load on walk handshake, count down while waiting, stop at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/tlb_walk_ctrl.sv
// tlb_walk_ctrl: sequencer in front of the 8-entry TLB. Looks up one request
// at a time, walks a single-level page table on a miss, fills the TLB and
// returns the physical address or a fault.
// Optional macro TLB_WALK_PERF_EN adds saturating perf_hits/perf_misses/perf_faults.
module tlb_walk_ctrl
  import mmu_pkg::*;
#(
  parameter int VA_W         = MMU_VA_W,
  parameter int PAGE_BITS    = MMU_PAGE_BITS,
  parameter int WALK_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [VA_W-1:0]           req_vaddr,
  output logic                      resp_valid,
  output logic [VA_W-1:0]           resp_paddr,
  output logic                      resp_fault,
  input  logic [VA_W-1:0]           ptbr,
  output logic [VA_W-1:0]           tlb_vaddr,
  input  logic                      tlb_hit,
  input  logic [VA_W-1:0]           tlb_paddr,
  output logic                      tlb_we,
  output logic [VA_W-PAGE_BITS-1:0] tlb_vpn,
  output logic [VA_W-PAGE_BITS-1:0] tlb_ppn,
  output logic                      tlb_dirty,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [VA_W-1:0]           mem_addr,
  input  logic                      mem_resp_valid,
  input  logic [VA_W-1:0]           mem_resp_data
`ifdef TLB_WALK_PERF_EN
  ,
  output logic [31:0]               perf_hits,
  output logic [31:0]               perf_misses,
  output logic [31:0]               perf_faults
`endif
);

  walk_state_e                 r_state;
  walk_state_e                 w_next;
  logic [VA_W-1:0]             r_vaddr;
  logic [VA_W-1:0]             r_ptbr;
  logic [VA_W-1:0]             r_mem_addr;
  logic [VA_W-PAGE_BITS-1:0]   r_pte_ppn;
  logic                        r_pte_d;

  logic                        w_resp_valid;
  logic                        w_resp_fault;
  logic [VA_W-1:0]             w_resp_paddr;
  logic                        w_tlb_we;
  logic                        w_mem_req_valid;
  logic                        w_to_load;
  logic                        w_to_en;
  logic                        w_to_expired;
  logic                        w_unused_pte_bits;

  // PTE bits [11:2] carry no meaning for this walker.
  assign w_unused_pte_bits = ^mem_resp_data[PTE_PPN_LSB-1:2];

  tlb_walk_timeout #(
    .WALK_TIMEOUT (WALK_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_to_load),
    .i_en      (w_to_en),
    .o_expired (w_to_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes; response data is muxed here from the
  // registered TLB result or the latched PTE.
  always_comb begin
    w_next          = r_state;
    w_resp_valid    = 1'b0;
    w_resp_fault    = 1'b0;
    w_resp_paddr    = {VA_W{1'b0}};
    w_tlb_we        = 1'b0;
    w_mem_req_valid = 1'b0;
    w_to_load       = 1'b0;
    w_to_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = ST_LOOKUP;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (tlb_hit) begin
          w_resp_valid = 1'b1;
          w_resp_paddr = tlb_paddr;
          w_next       = ST_IDLE;
        end else begin
          w_next       = ST_WALK_REQ;
        end
      end
      ST_WALK_REQ: begin
        w_mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_to_load = 1'b1;
          w_next    = ST_WALK_WAIT;
        end else begin
          w_next    = ST_WALK_REQ;
        end
      end
      ST_WALK_WAIT: begin
        w_to_en = 1'b1;
        if (mem_resp_valid) begin
          if (mem_resp_data[PTE_V]) begin
            w_next       = ST_FILL;
          end else begin
            w_resp_valid = 1'b1;
            w_resp_fault = 1'b1;
            w_next       = ST_IDLE;
          end
        end else if (w_to_expired) begin
          w_resp_valid = 1'b1;
          w_resp_fault = 1'b1;
          w_next       = ST_IDLE;
        end else begin
          w_next       = ST_WALK_WAIT;
        end
      end
      ST_FILL: begin
        w_tlb_we     = 1'b1;
        w_resp_valid = 1'b1;
        w_resp_paddr = {r_pte_ppn, r_vaddr[PAGE_BITS-1:0]};
        w_next       = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request, PTE address and PTE latches; vaddr stays stable for the TLB until
  // the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vaddr    <= {VA_W{1'b0}};
      r_ptbr     <= {VA_W{1'b0}};
      r_mem_addr <= {VA_W{1'b0}};
      r_pte_ppn  <= {(VA_W-PAGE_BITS){1'b0}};
      r_pte_d    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && req_valid) begin
        r_vaddr <= req_vaddr;
        r_ptbr  <= ptbr;
      end
      if ((r_state == ST_CHECK) && !tlb_hit) begin
        r_mem_addr <= pte_addr(r_ptbr, r_vaddr[VA_W-1:PAGE_BITS]);
      end
      if ((r_state == ST_WALK_WAIT) && mem_resp_valid && mem_resp_data[PTE_V]) begin
        r_pte_ppn <= mem_resp_data[VA_W-1:PTE_PPN_LSB];
        r_pte_d   <= mem_resp_data[PTE_D];
      end
    end
  end

  assign req_ready     = (r_state == ST_IDLE);
  assign resp_valid    = w_resp_valid;
  assign resp_fault    = w_resp_fault;
  assign resp_paddr    = w_resp_paddr;
  assign tlb_vaddr     = r_vaddr;
  assign tlb_we        = w_tlb_we;
  assign tlb_vpn       = r_vaddr[VA_W-1:PAGE_BITS];
  assign tlb_ppn       = r_pte_ppn;
  assign tlb_dirty     = r_pte_d;
  assign mem_req_valid = w_mem_req_valid;
  assign mem_addr      = r_mem_addr;

`ifdef TLB_WALK_PERF_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;
  logic [31:0] r_perf_faults;
  logic        w_ev_hit;
  logic        w_ev_miss;
  logic        w_ev_fault;

  assign w_ev_hit   = (r_state == ST_CHECK) && tlb_hit;
  assign w_ev_miss  = (r_state == ST_CHECK) && !tlb_hit;
  assign w_ev_fault = w_resp_valid && w_resp_fault;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_hits   <= 32'd0;
      r_perf_misses <= 32'd0;
      r_perf_faults <= 32'd0;
    end else begin
      if (w_ev_hit && (r_perf_hits != 32'hFFFF_FFFF)) begin
        r_perf_hits <= r_perf_hits + 32'd1;
      end
      if (w_ev_miss && (r_perf_misses != 32'hFFFF_FFFF)) begin
        r_perf_misses <= r_perf_misses + 32'd1;
      end
      if (w_ev_fault && (r_perf_faults != 32'hFFFF_FFFF)) begin
        r_perf_faults <= r_perf_faults + 32'd1;
      end
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
  assign perf_faults = r_perf_faults;
`endif

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
// tb_tlb_walk_ctrl: self-checking bench for tlb_walk_ctrl. Provides a simple
// 8-entry TLB and a scripted memory, predicts every transaction from a
// transaction-level model, and checks DUT outputs on every cycle.
module tb_tlb_walk_ctrl;

  localparam int WT    = 255;
  localparam int NEVER = -1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_vaddr, ptbr;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_paddr, tlb_vaddr;
  logic        tlb_hit = 1'b0;
  logic [31:0] tlb_paddr = 32'h0;
  logic        tlb_we, tlb_dirty;
  logic [19:0] tlb_vpn, tlb_ppn;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_addr, mem_resp_data;
`ifdef TLB_WALK_PERF_EN
  logic [31:0] perf_hits, perf_misses, perf_faults;
`endif

  tlb_walk_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_fault(resp_fault),
    .ptbr(ptbr), .tlb_vaddr(tlb_vaddr), .tlb_hit(tlb_hit), .tlb_paddr(tlb_paddr),
    .tlb_we(tlb_we), .tlb_vpn(tlb_vpn), .tlb_ppn(tlb_ppn), .tlb_dirty(tlb_dirty),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef TLB_WALK_PERF_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_faults(perf_faults)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- environment TLB (written only by the DUT / preload) ----
  logic [19:0] e_vpn [8];
  logic [19:0] e_ppn [8];
  int          e_n = 0;
  logic        pl_we = 1'b0;
  logic [19:0] pl_vpn = 20'h0, pl_ppn = 20'h0;

  function automatic int e_find(input logic [19:0] v);
    for (int i = 0; i < e_n; i++) if (e_vpn[i] == v) return i;
    return -1;
  endfunction

  function automatic logic [19:0] e_ppn_of(input logic [19:0] v);
    int k = e_find(v);
    return (k >= 0) ? e_ppn[k] : 20'h0;
  endfunction

  // Registered lookup of tlb_vaddr each cycle; fills dropped when full.
  always @(posedge clk) begin
    tlb_hit   <= (e_find(tlb_vaddr[31:12]) >= 0);
    tlb_paddr <= {e_ppn_of(tlb_vaddr[31:12]), tlb_vaddr[11:0]};
    if (tlb_we && e_n < 8) begin
      e_vpn[e_n] <= tlb_vpn; e_ppn[e_n] <= tlb_ppn; e_n <= e_n + 1;
    end else if (pl_we && e_n < 8) begin
      e_vpn[e_n] <= pl_vpn; e_ppn[e_n] <= pl_ppn; e_n <= e_n + 1;
    end
  end

  // ---------------- reference model: expected TLB contents + timeline ------
  logic [19:0] m_vpn [8];
  logic [19:0] m_ppn [8];
  int          m_n = 0;
  int          m_hits = 0, m_misses = 0, m_faults = 0;

  function automatic int m_find(input logic [19:0] v);
    for (int i = 0; i < m_n; i++) if (m_vpn[i] == v) return i;
    return -1;
  endfunction

  // Expected timeline of the current transaction, in cycle numbers.
  int          t_a = NEVER, t_end = NEVER, t_resp = NEVER;
  int          t_mlo = NEVER, t_mhi = NEVER, t_we = NEVER;
  logic        t_fault = 1'b0, t_we_d = 1'b0;
  logic [31:0] t_paddr = 32'h0, t_maddr = 32'h0, t_va = 32'h0;
  logic [19:0] t_we_vpn = 20'h0, t_we_ppn = 20'h0;

  // Observations recorded for the directed literal checks.
  int          obs_resp_cnt = 0, obs_mreq_cnt = 0, obs_we_cnt = 0;
  int          obs_resp_cyc = 0, obs_hs_cyc = 0;
  logic        obs_fault = 1'b0;
  logic [31:0] obs_paddr = 32'h0, obs_maddr = 32'h0;
  logic [19:0] obs_we_vpn = 20'h0, obs_we_ppn = 20'h0;
  logic        obs_we_d = 1'b0;

  // Single compare process: every cycle, DUT outputs against the model timeline.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("req_ready", 32'(req_ready), 32'(!(cyc >= t_a && cyc <= t_end)));
      check("resp_valid", 32'(resp_valid), 32'(cyc == t_resp));
      check("mem_req_valid", 32'(mem_req_valid), 32'(cyc >= t_mlo && cyc <= t_mhi));
      check("tlb_we", 32'(tlb_we), 32'(cyc == t_we));
      if (cyc == t_resp) begin
        check("resp_paddr", resp_paddr, t_paddr);
        check("resp_fault", 32'(resp_fault), 32'(t_fault));
      end
      if (cyc >= t_mlo && cyc <= t_mhi) check("mem_addr", mem_addr, t_maddr);
      if (cyc == t_we) begin
        check("tlb_vpn", 32'(tlb_vpn), 32'(t_we_vpn));
        check("tlb_ppn", 32'(tlb_ppn), 32'(t_we_ppn));
        check("tlb_dirty", 32'(tlb_dirty), 32'(t_we_d));
      end
      if (cyc >= t_a && cyc <= t_end) check("tlb_vaddr", tlb_vaddr, t_va);
    end
    if (resp_valid) begin
      obs_resp_cnt++; obs_paddr = resp_paddr; obs_fault = resp_fault; obs_resp_cyc = cyc;
    end
    if (mem_req_valid) begin
      obs_mreq_cnt++; obs_maddr = mem_addr;
      if (mem_req_ready) obs_hs_cyc = cyc;
    end
    if (tlb_we) begin
      obs_we_cnt++; obs_we_vpn = tlb_vpn; obs_we_ppn = tlb_ppn; obs_we_d = tlb_dirty;
    end
  end

  // Advance to just after the posedge that starts cycle n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic preload(input logic [19:0] v, input logic [19:0] p);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_vpn = v; pl_ppn = p;
    m_vpn[m_n] = v; m_ppn[m_n] = p; m_n++;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // One translation. d1: cycles of mem_req_valid before ready; d2: cycles into
  // the wait before the PTE arrives (<0 never, >=WT late). rst_mid: reset in the wait.
  task automatic run_txn(input logic [31:0] va, input logic [31:0] pb, input logic [31:0] pte,
                         input int d1, input int d2, input bit rst_mid);
    int a, s, idx, last;
    logic [19:0] vpn;
    @(posedge clk); #1;
    req_valid = 1'b1; req_vaddr = va; ptbr = pb;
    a = cyc + 1; vpn = va[31:12]; idx = m_find(vpn);
    t_a = a; t_va = va; t_we = NEVER; last = a + 1;
    if (idx >= 0) begin
      t_resp = a + 1; t_end = a + 1; t_fault = 1'b0;
      t_paddr = {m_ppn[idx], va[11:0]};
      t_mlo = NEVER; t_mhi = NEVER;
      m_hits++;
    end else begin
      m_misses++;
      t_mlo = a + 2; t_mhi = a + 2 + d1;
      t_maddr = pb + ({12'h0, vpn} << 2);
      s = a + 3 + d1;
      if (rst_mid) begin
        t_resp = NEVER; t_end = 1000000000;
      end else if (d2 >= 0 && d2 < WT && pte[0]) begin
        t_resp = s + d2 + 1; t_we = t_resp; t_end = t_resp; t_fault = 1'b0;
        t_paddr = {pte[31:12], va[11:0]};
        t_we_vpn = vpn; t_we_ppn = pte[31:12]; t_we_d = pte[1];
        if (m_n < 8) begin m_vpn[m_n] = vpn; m_ppn[m_n] = pte[31:12]; m_n++; end
      end else begin
        t_resp = (d2 >= 0 && d2 < WT) ? s + d2 : s + WT - 1;
        t_end = t_resp; t_fault = 1'b1; t_paddr = 32'h0;
        m_faults++;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_vaddr = $urandom; ptbr = $urandom;
    if (idx < 0) begin
      wait_cyc(a + 2 + d1); mem_req_ready = 1'b1;
      wait_cyc(a + 3 + d1); mem_req_ready = 1'b0;
      if (rst_mid) begin
        wait_cyc(s + 2); reset = 1'b1; t_end = cyc - 1;
        m_hits = 0; m_misses = 0; m_faults = 0;
        wait_cyc(s + 3); reset = 1'b0;
        wait_cyc(s + 4); mem_resp_valid = 1'b1; mem_resp_data = pte;
        wait_cyc(s + 5); mem_resp_valid = 1'b0;
        last = s + 5;
      end else if (d2 >= 0) begin
        wait_cyc(s + d2); mem_resp_valid = 1'b1; mem_resp_data = pte;
        wait_cyc(s + d2 + 1); mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        last = s + d2 + 1;
      end
    end
    wait_cyc(((last > t_end) ? last : t_end) + 1);
  endtask

  int c0, w0, r0;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_vaddr = 32'h0; ptbr = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    repeat (3) @(negedge clk);
    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_paddr", resp_paddr, 32'h0);
    check("rst_tlb_vaddr", tlb_vaddr, 32'h0);
    check("rst_tlb_vpn_ppn", 32'({tlb_vpn, tlb_ppn[11:0]}), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_strobes", 32'({tlb_we, tlb_dirty, mem_req_valid, resp_fault}), 32'h0);
    @(posedge clk); #1; reset = 1'b0;

    // Hit path: response in the third cycle counting the accept cycle
    preload(20'h12345, 20'hABCDE);
    c0 = obs_mreq_cnt;
    run_txn(32'h12345678, 32'h0, 32'h0, 0, 0, 1'b0);
    check("model_hit_paddr", t_paddr, 32'hABCDE678);
    check("hit_paddr", obs_paddr, 32'hABCDE678);
    check("hit_fault", 32'(obs_fault), 32'h0);
    check("hit_latency", 32'(obs_resp_cyc - (t_a - 1)), 32'd2);
    check("hit_no_mem", 32'(obs_mreq_cnt - c0), 32'h0);

    // Miss + fill, then repeat must hit
    run_txn(32'h00002ABC, 32'h00100000, 32'h55555003, 1, 2, 1'b0);
    check("model_fill_maddr", t_maddr, 32'h00100008);
    check("fill_maddr", obs_maddr, 32'h00100008);
    check("fill_vpn", 32'(obs_we_vpn), 32'h00002);
    check("fill_ppn", 32'(obs_we_ppn), 32'h55555);
    check("fill_dirty", 32'(obs_we_d), 32'h1);
    check("fill_paddr", obs_paddr, 32'h55555ABC);
    c0 = obs_mreq_cnt;
    run_txn(32'h00002ABC, 32'h00100000, 32'h0, 0, 0, 1'b0);
    check("refill_hit_no_mem", 32'(obs_mreq_cnt - c0), 32'h0);
    check("refill_hit_paddr", obs_paddr, 32'h55555ABC);

    // PTE address wraps modulo 2^32
    run_txn(32'h00001000, 32'hFFFFFFFC, 32'h00777001, 0, 0, 1'b0);
    check("wrap_maddr", obs_maddr, 32'h00000000);

    // Invalid PTE
    w0 = obs_we_cnt;
    run_txn(32'h00003123, 32'h00100000, 32'h55555002, 2, 1, 1'b0);
    check("inv_fault", 32'(obs_fault), 32'h1);
    check("inv_paddr", obs_paddr, 32'h0);
    check("inv_no_we", 32'(obs_we_cnt - w0), 32'h0);

    // Timeout, with a late response afterwards
    r0 = obs_resp_cnt;
    run_txn(32'h00004000, 32'h00100000, 32'h11111001, 0, WT + 2, 1'b0);
    check("to_fault", 32'(obs_fault), 32'h1);
    check("to_cycles", 32'(obs_resp_cyc - obs_hs_cyc), 32'(WT));
    check("to_late_ignored", 32'(obs_resp_cnt - r0), 32'h1);

    // Fill to 8 entries, then a 9th VPN misses and its fill is dropped
    for (int v = 16; v < 21; v++)
      run_txn({12'h0, v[7:0], 12'h0} | 32'($urandom_range(4095, 0)), 32'h00100000,
              {12'h0, v[7:0] + 8'h40, 12'h001}, 0, 1, 1'b0);
    run_txn(32'h00020345, 32'h00200000, 32'h0ABCD001, 0, 0, 1'b0);
    check("full_paddr", obs_paddr, 32'h0ABCD345);
    c0 = obs_mreq_cnt;
    run_txn(32'h00020345, 32'h00200000, 32'h0ABCD001, 1, 0, 1'b0);
    check("full_remiss", 32'(obs_mreq_cnt - c0 > 0), 32'h1);
    check("full_paddr2", obs_paddr, 32'h0ABCD345);

    // Reset mid-walk, then a normal request
    r0 = obs_resp_cnt;
    run_txn(32'h00030000, 32'h00100000, 32'h12345001, 0, 3, 1'b1);
    check("rstmid_no_resp", 32'(obs_resp_cnt - r0), 32'h0);
    check("rstmid_tlb_vaddr", tlb_vaddr, 32'h0);
    run_txn(32'h12345678, 32'h0, 32'h0, 0, 0, 1'b0);
    check("rstmid_after_paddr", obs_paddr, 32'hABCDE678);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] va, pb, pte;
      int d2, r, k;
      if ($urandom_range(1, 0) == 1) begin
        k = $urandom_range(m_n - 1, 0);
        va = {m_vpn[k], 12'($urandom)};
      end else begin
        va = $urandom;
      end
      pb = $urandom & 32'hFFFFFFFC;
      pte = $urandom;
      pte[0] = ($urandom_range(3, 0) != 0);
      r = $urandom_range(19, 0);
      if (r < 16) d2 = $urandom_range(5, 0);
      else if (r < 18) d2 = -1;
      else d2 = WT + $urandom_range(3, 0);
      run_txn(va, pb, pte, $urandom_range(3, 0), d2, 1'b0);
    end

`ifdef TLB_WALK_PERF_EN
    check("perf_hits", perf_hits, 32'(m_hits));
    check("perf_misses", perf_misses, 32'(m_misses));
    check("perf_faults", perf_faults, 32'(m_faults));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
